// File: rtl/tof_frame_buf.sv
// Per-trigger TOF result buffer: drops start event and out-of-range codes, stores up to DEPTH stops,
// then drains a header plus stored results; rd_valid 1 cycle after window close, frame_done 1 cycle after last accept.
// Readout stalls on rd_ready low with rd_data held; optional TOF_DROP_CNT_EN adds a discard count in header[7:0].
module tof_frame_buf #(
  parameter int DATA_W  = 19,
  parameter int DEPTH   = 5,
  parameter int TIMEOUT = 4000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tri_en,
  input  logic              out_valid,
  input  logic [DATA_W-1:0] tof_data_in,
  input  logic [2:0]        tof_num_cnt,
  output logic [23:0]       rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              frame_done,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, WAIT_START, COLLECT, DRAIN} state_t;

  localparam int              WIN_W    = $clog2(TIMEOUT);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(TIMEOUT - 1);
  localparam logic [2:0]      DEPTH3   = 3'(DEPTH);

  state_t             state;
  logic [WIN_W-1:0]   win_cnt;
  logic [2:0]         wr_ptr;
  logic [2:0]         stop_cnt;
  logic [2:0]         exp_num;
  logic [2:0]         rd_idx;
  logic               ovf;
  logic               tmo;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic               in_window;
  logic               stop_evt;
  logic               oor;
  logic               wr_en;
  logic [2:0]         stop_nxt;
  logic               tmo_hit;
  logic [2:0]         word_idx;
  logic [18:0]        word_dat;
  logic [17:0]        hdr_low;

  assign in_window = (state == WAIT_START) || (state == COLLECT);
  assign stop_evt  = (state == COLLECT) && out_valid && !tri_en;
  assign oor       = &tof_data_in;
  assign wr_en     = stop_evt && !oor && (wr_ptr < DEPTH3);
  assign stop_nxt  = (stop_cnt == 3'd7) ? 3'd7 : stop_cnt + 3'd1;
  assign tmo_hit   = in_window && (win_cnt == WIN_LAST);
  assign busy      = (state != IDLE);

`ifdef TOF_DROP_CNT_EN
  logic [7:0] drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (tri_en) begin
      drop_cnt <= '0;
    end else if (stop_evt && (oor || (wr_ptr >= DEPTH3)) && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign hdr_low = {10'd0, drop_cnt};
`else
  assign hdr_low = '0;
`endif

  // Word k (k>=1) carries mem[k-1]; rd_idx counts words already accepted.
  assign word_idx = rd_idx - 3'd1;
  assign word_dat = (word_idx < DEPTH3) ? 19'(mem[word_idx]) : '0;
  assign rd_data  = !rd_valid     ? 24'd0 :
                    (rd_idx == 0) ? {1'b1, wr_ptr, ovf, tmo, hdr_low} :
                                    {1'b0, word_idx, 1'b0, word_dat};

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= tof_data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      win_cnt    <= '0;
      wr_ptr     <= '0;
      stop_cnt   <= '0;
      exp_num    <= '0;
      rd_idx     <= '0;
      ovf        <= 1'b0;
      tmo        <= 1'b0;
      rd_valid   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // A trigger restarts the frame from any state, discarding anything in flight.
      if (tri_en) begin
        state    <= WAIT_START;
        win_cnt  <= '0;
        wr_ptr   <= '0;
        stop_cnt <= '0;
        rd_idx   <= '0;
        ovf      <= 1'b0;
        tmo      <= 1'b0;
        rd_valid <= 1'b0;
      end else begin
        case (state)
          WAIT_START: begin
            if (win_cnt == '0) exp_num <= (tof_num_cnt == 3'd0) ? DEPTH3 : tof_num_cnt;
            win_cnt <= win_cnt + WIN_W'(1);
            if (out_valid) state <= COLLECT;
            if (tmo_hit) begin
              tmo      <= 1'b1;
              state    <= DRAIN;
              rd_valid <= 1'b1;
              rd_idx   <= '0;
            end
          end
          COLLECT: begin
            win_cnt <= win_cnt + WIN_W'(1);
            if (out_valid) begin
              stop_cnt <= stop_nxt;
              if (wr_en)                        wr_ptr <= wr_ptr + 3'd1;
              else if (!oor)                    ovf    <= 1'b1;
            end
            if ((out_valid && (stop_nxt == exp_num)) || tmo_hit) begin
              if (tmo_hit) tmo <= 1'b1;
              state    <= DRAIN;
              rd_valid <= 1'b1;
              rd_idx   <= '0;
            end
          end
          DRAIN: begin
            if (rd_valid && rd_ready) begin
              if (rd_idx == wr_ptr) begin
                rd_valid   <= 1'b0;
                frame_done <= 1'b1;
                state      <= IDLE;
              end else begin
                rd_idx <= rd_idx + 3'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
